// File: rtl/antares_count_leading_pkg.sv
// Shared definitions for the CLZ/CLO unit: state encoding, datapath widths and
// the STEP_BITS legality check.
package antares_count_leading_pkg;

   localparam int unsigned CL_WIDTH = 32;
   localparam int unsigned CL_RES_W = 6;

   typedef enum logic [1:0] {
      CL_IDLE = 2'd0,
      CL_SCAN = 2'd1,
      CL_DONE = 2'd2
   } cl_state_t;

   function automatic logic cl_step_legal(input int unsigned step);
      return (step == 1) || (step == 2) || (step == 4) ||
             (step == 8) || (step == 16) || (step == 32);
   endfunction

endpackage

// File: rtl/antares_count_leading_chunk.sv
// antares_clz_chunk: combinational leading-zero count of one STEP_BITS-wide
// chunk (0..STEP_BITS) plus an all-zero flag.
module antares_clz_chunk
   import antares_count_leading_pkg::*;
#(
   parameter int unsigned STEP_BITS = 4
) (
   input  logic [STEP_BITS-1:0] i_chunk,
   output logic [CL_RES_W-1:0]  o_lz,
   output logic                 o_all_zero
);

   logic [STEP_BITS-1:0] w_tmp;
   logic [CL_RES_W-1:0]  w_lz;
   logic                 w_found;

   // Shift the chunk up so only the fixed MSB position is ever tested.
   always_comb begin
      w_tmp   = i_chunk;
      w_lz    = '0;
      w_found = 1'b0;
      for (int unsigned i = 0; i < STEP_BITS; i++) begin
         if (!w_found) begin
            if (w_tmp[STEP_BITS-1]) begin
               w_found = 1'b1;
            end else begin
               w_lz  = w_lz + CL_RES_W'(1);
               w_tmp = w_tmp << 1;
            end
         end
      end
   end

   assign o_lz       = w_lz;
   assign o_all_zero = ~|i_chunk;

endmodule

// File: rtl/antares_count_leading.sv
// Iterative CLZ/CLO unit: scans STEP_BITS per cycle from the MSB, exits early.
// Optional macro ANTARES_CLZ_ZERO_FASTPATH_EN sends all-zero operands straight to DONE.
module antares_count_leading
   import antares_count_leading_pkg::*;
#(
   parameter int unsigned STEP_BITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cl_start,
   input  logic [31:0]         cl_input_data,
   input  logic                cl_count_ones,
   input  logic                cl_flush,
   output logic                cl_busy,
   output logic                cl_done,
   output logic [5:0]          cl_result
);

   if (!cl_step_legal(STEP_BITS)) begin : g_bad_step
      $fatal(1, "antares_count_leading: STEP_BITS must be 1, 2, 4, 8, 16 or 32");
   end

   localparam logic [CL_RES_W-1:0] LP_STEP = CL_RES_W'(STEP_BITS);
   localparam logic [CL_RES_W-1:0] LP_FULL = CL_RES_W'(CL_WIDTH);

   cl_state_t             r_state;
   logic [CL_WIDTH-1:0]   r_operand;
   logic [CL_RES_W-1:0]   r_count;
   logic                  r_done;
   logic [CL_RES_W-1:0]   r_result;

   logic [CL_WIDTH-1:0]   w_operand;
   logic [CL_RES_W-1:0]   w_chunk_lz;
   logic                  w_chunk_zero;
   logic [CL_RES_W-1:0]   w_count_step;
   logic [CL_RES_W-1:0]   w_count_lz;

   // CLO is handled by inverting the operand, so the datapath only counts zeros.
   assign w_operand    = cl_count_ones ? ~cl_input_data : cl_input_data;
   assign w_count_step = r_count + LP_STEP;
   assign w_count_lz   = r_count + w_chunk_lz;

   antares_clz_chunk #(
      .STEP_BITS (STEP_BITS)
   ) u_chunk (
      .i_chunk    (r_operand[CL_WIDTH-1 -: STEP_BITS]),
      .o_lz       (w_chunk_lz),
      .o_all_zero (w_chunk_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= CL_IDLE;
         r_operand <= '0;
         r_count   <= '0;
         r_done    <= 1'b0;
         r_result  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            CL_IDLE: begin
               if (cl_start && !cl_flush) begin
                  r_operand <= w_operand;
`ifdef ANTARES_CLZ_ZERO_FASTPATH_EN
                  if (w_operand == '0) begin
                     r_count <= LP_FULL;
                     r_state <= CL_DONE;
                  end else begin
                     r_count <= '0;
                     r_state <= CL_SCAN;
                  end
`else
                  r_count <= '0;
                  r_state <= CL_SCAN;
`endif
               end
            end
            CL_SCAN: begin
               if (cl_flush) begin
                  r_state <= CL_IDLE;
               end else if (w_chunk_zero) begin
                  r_count   <= w_count_step;
                  r_operand <= r_operand << STEP_BITS;
                  if (w_count_step == LP_FULL) begin
                     r_state <= CL_DONE;
                  end
               end else begin
                  r_count <= w_count_lz;
                  r_state <= CL_DONE;
               end
            end
            CL_DONE: begin
               if (!cl_flush) begin
                  r_done   <= 1'b1;
                  r_result <= r_count;
               end
               r_state <= CL_IDLE;
            end
            default: r_state <= CL_IDLE;
         endcase
      end
   end

   assign cl_busy   = (r_state != CL_IDLE);
   assign cl_done   = r_done;
   assign cl_result = r_result;

endmodule
